jm_kernel_dispatcher: RTL and testbench



---
 rtl/jm_kernel_dispatcher.sv | 156 +++++++++++++++
 tb/tb_jm_kernel_dispatcher.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jm_kernel_dispatcher.sv
// jm_kernel_dispatcher: buffers job descriptors, dispatches them to up to 16 kernels
// (round-robin or fixed priority) and collects tagged completions round-robin.
module jm_kernel_dispatcher #(
    parameter int HOST_DWIDTH  = 1024,
    parameter int RETURN_WIDTH = 41,
    parameter int KERNEL_NUM   = 2,
    parameter int DSC_DEPTH    = 4,
    parameter int KID_WIDTH    = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               mode_i,
    input  logic [KERNEL_NUM-1:0]              kernel_en_i,
    input  logic                               flush_i,
    input  logic                               dsc_ready_i,
    input  logic [HOST_DWIDTH-1:0]             dsc_data_i,
    output logic                               dsc_pull_o,
    output logic [KERNEL_NUM-1:0]              kernel_start,
    output logic [HOST_DWIDTH-1:0]             kernel_data,
    input  logic [KERNEL_NUM-1:0]              kernel_ready,
    input  logic [KERNEL_NUM-1:0]              complete_ready,
    input  logic [RETURN_WIDTH*KERNEL_NUM-1:0] complete_data,
    output logic [KERNEL_NUM-1:0]              complete_accept,
    output logic                               complete_push_o,
    output logic [RETURN_WIDTH-1:0]            return_data_o,
    output logic [KID_WIDTH-1:0]               return_kid_o,
    input  logic                               complete_ready_i,
    output logic [KERNEL_NUM-1:0]              busy_o,
    output logic [CNT_WIDTH-1:0]               dispatch_cnt_o,
    output logic [CNT_WIDTH-1:0]               complete_cnt_o,
    output logic                               err_spurious_o,
    output logic                               idle_o
);
    localparam int AW = $clog2(DSC_DEPTH);

    logic [HOST_DWIDTH-1:0]  mem_q [DSC_DEPTH];
    logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]             cnt_q, cnt_d;
    logic [KID_WIDTH-1:0]    rr_q, rr_d, cmp_rr_q, cmp_rr_d;
    logic [KERNEL_NUM-1:0]   start_q, start_d, busy_q, busy_d;
    logic [HOST_DWIDTH-1:0]  kdata_q, kdata_d;
    logic [CNT_WIDTH-1:0]    dcnt_q, dcnt_d, ccnt_q, ccnt_d;
    logic                    push_q, push_d, err_q, err_d;
    logic [RETURN_WIDTH-1:0] rdata_q, rdata_d;
    logic [KID_WIDTH-1:0]    rkid_q, rkid_d;

    logic                    fifo_full, fifo_empty, fifo_push;
    logic [KERNEL_NUM-1:0]   elig, cand, disp_oh, cmp_oh;
    logic                    disp_fire, cmp_fire, load_en;
    logic [KID_WIDTH-1:0]    disp_kid, cmp_kid;

    // First requester after ptr with wrap-around, or lowest index when prio is set.
    function automatic logic [KID_WIDTH-1:0] pick(input logic [KERNEL_NUM-1:0] req,
                                                  input logic [KID_WIDTH-1:0] ptr,
                                                  input logic prio);
        logic [KID_WIDTH-1:0] sel;
        logic                 hit;
        int                   j;
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < KERNEL_NUM; i++) begin
            j = prio ? i : int'(ptr) + 1 + i;
            if (j >= KERNEL_NUM) j -= KERNEL_NUM;
            if (!hit && req[j]) begin
                hit = 1'b1;
                sel = KID_WIDTH'(j);
            end
        end
        return sel;
    endfunction

    assign fifo_full  = cnt_q == (AW+1)'(DSC_DEPTH);
    assign fifo_empty = cnt_q == '0;
    assign elig       = (fifo_empty || flush_i) ? '0 : kernel_ready & kernel_en_i & ~busy_q;
    assign disp_fire  = |elig;
    assign disp_kid   = pick(elig, rr_q, mode_i);
    assign disp_oh    = disp_fire ? KERNEL_NUM'(1) << disp_kid : '0;
    // A full FIFO may still take a descriptor when the head leaves in the same cycle.
    assign dsc_pull_o = !flush_i && (!fifo_full || disp_fire);
    assign fifo_push  = dsc_pull_o && dsc_ready_i;

    assign cand            = complete_ready & busy_q;
    assign load_en         = !push_q || complete_ready_i;
    assign cmp_fire        = load_en && |cand;
    assign cmp_kid         = pick(cand, cmp_rr_q, 1'b0);
    assign cmp_oh          = cmp_fire ? KERNEL_NUM'(1) << cmp_kid : '0;
    assign complete_accept = cmp_oh;

    always_comb begin
        wr_d     = flush_i ? '0 : wr_q + AW'(fifo_push);
        rd_d     = flush_i ? '0 : rd_q + AW'(disp_fire);
        cnt_d    = flush_i ? '0 : cnt_q + (AW+1)'(fifo_push) - (AW+1)'(disp_fire);
        start_d  = disp_oh;
        kdata_d  = disp_fire ? mem_q[rd_q] : kdata_q;
        rr_d     = disp_fire ? disp_kid : rr_q;
        dcnt_d   = dcnt_q + CNT_WIDTH'(disp_fire);
        busy_d   = (busy_q | disp_oh) & ~cmp_oh;
        cmp_rr_d = cmp_fire ? cmp_kid : cmp_rr_q;
        push_d   = cmp_fire || (push_q && !complete_ready_i);
        rdata_d  = cmp_fire ? complete_data[int'(cmp_kid)*RETURN_WIDTH +: RETURN_WIDTH] : rdata_q;
        rkid_d   = cmp_fire ? cmp_kid : rkid_q;
        ccnt_d   = ccnt_q + CNT_WIDTH'(cmp_fire);
        err_d    = err_q || |(complete_ready & ~busy_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            start_q  <= '0;
            kdata_q  <= '0;
            rr_q     <= KID_WIDTH'(KERNEL_NUM - 1);
            dcnt_q   <= '0;
            busy_q   <= '0;
            cmp_rr_q <= KID_WIDTH'(KERNEL_NUM - 1);
            push_q   <= 1'b0;
            rdata_q  <= '0;
            rkid_q   <= '0;
            ccnt_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            kdata_q  <= kdata_d;
            rr_q     <= rr_d;
            dcnt_q   <= dcnt_d;
            busy_q   <= busy_d;
            cmp_rr_q <= cmp_rr_d;
            push_q   <= push_d;
            rdata_q  <= rdata_d;
            rkid_q   <= rkid_d;
            ccnt_q   <= ccnt_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (fifo_push) mem_q[wr_q] <= dsc_data_i;
    end

    assign kernel_start    = start_q;
    assign kernel_data     = kdata_q;
    assign busy_o          = busy_q;
    assign dispatch_cnt_o  = dcnt_q;
    assign complete_cnt_o  = ccnt_q;
    assign complete_push_o = push_q;
    assign return_data_o   = rdata_q;
    assign return_kid_o    = rkid_q;
    assign err_spurious_o  = err_q;
    assign idle_o          = fifo_empty && busy_q == '0 && !push_q;
endmodule

// File: tb/tb_jm_kernel_dispatcher.sv
// tb_jm_kernel_dispatcher: directed checks of dispatch, completion, flush and reset behaviour.
module tb_jm_kernel_dispatcher;
    localparam int HW = 64, RW = 41, KN = 4, DD = 4, KW = 4, CW = 32;

    logic              clk = 1'b0, resetn = 1'b0;
    logic              mode_i = 1'b0, flush_i = 1'b0, dsc_ready_i = 1'b0, complete_ready_i = 1'b1;
    logic [KN-1:0]     kernel_en_i = '1, kernel_ready = '0, complete_ready = '0;
    logic [HW-1:0]     dsc_data_i = '0;
    logic [RW*KN-1:0]  complete_data = '0;
    logic              dsc_pull_o, complete_push_o, err_spurious_o, idle_o;
    logic [KN-1:0]     kernel_start, complete_accept, busy_o;
    logic [HW-1:0]     kernel_data;
    logic [RW-1:0]     return_data_o;
    logic [KW-1:0]     return_kid_o;
    logic [CW-1:0]     dispatch_cnt_o, complete_cnt_o;
    int                tests = 0, fails = 0;

    jm_kernel_dispatcher #(.HOST_DWIDTH(HW), .RETURN_WIDTH(RW), .KERNEL_NUM(KN),
                           .DSC_DEPTH(DD), .KID_WIDTH(KW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .resetn(resetn), .mode_i(mode_i), .kernel_en_i(kernel_en_i), .flush_i(flush_i),
        .dsc_ready_i(dsc_ready_i), .dsc_data_i(dsc_data_i), .dsc_pull_o(dsc_pull_o),
        .kernel_start(kernel_start), .kernel_data(kernel_data), .kernel_ready(kernel_ready),
        .complete_ready(complete_ready), .complete_data(complete_data),
        .complete_accept(complete_accept), .complete_push_o(complete_push_o),
        .return_data_o(return_data_o), .return_kid_o(return_kid_o),
        .complete_ready_i(complete_ready_i), .busy_o(busy_o), .dispatch_cnt_o(dispatch_cnt_o),
        .complete_cnt_o(complete_cnt_o), .err_spurious_o(err_spurious_o), .idle_o(idle_o));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [HW-1:0] d);
        dsc_ready_i = 1'b1;
        dsc_data_i  = d;
        @(negedge clk);
        dsc_ready_i = 1'b0;
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic set_cd(input int k, input logic [RW-1:0] v);
        complete_data[k*RW +: RW] = v;
    endtask

    initial begin
        @(negedge clk);
        chk("rst_start", kernel_start, 0);
        chk("rst_kdata", kernel_data, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_dcnt", dispatch_cnt_o, 0);
        chk("rst_push", complete_push_o, 0);
        chk("rst_idle", idle_o, 1);
        chk("rst_pull", dsc_pull_o, 1);
        resetn = 1'b1;
        kernel_ready = 4'hF;

        // single descriptor, two-cycle latency
        push(64'hA5A5_A5A5_A5A5_A5A5);
        chk("t1_no_start_yet", kernel_start, 0);
        @(negedge clk);
        chk("t1_start", kernel_start, 4'b0001);
        chk("t1_kdata", kernel_data, 64'hA5A5_A5A5_A5A5_A5A5);
        chk("t1_busy", busy_o, 4'b0001);
        chk("t1_dcnt", dispatch_cnt_o, 1);
        @(negedge clk);
        chk("t1_start_pulse", kernel_start, 0);
        complete_ready = 4'b0001;
        set_cd(0, 41'h1AB_CDEF_0123);
        #1 chk("t1_accept", complete_accept, 4'b0001);
        @(negedge clk);
        complete_ready = '0;
        chk("t1_push", complete_push_o, 1);
        chk("t1_rdata", return_data_o, 41'h1AB_CDEF_0123);
        chk("t1_kid", return_kid_o, 0);
        chk("t1_busy_clr", busy_o, 0);
        chk("t1_ccnt", complete_cnt_o, 1);
        chk("t1_not_idle", idle_o, 0);
        @(negedge clk);
        chk("t1_push_drop", complete_push_o, 0);
        chk("t1_idle", idle_o, 1);

        // round-robin order k0..k3, then wrap to k0
        do_reset;
        push(64'hD0);
        push(64'hD1);
        chk("t2_s0", kernel_start, 4'b0001);
        chk("t2_d0", kernel_data, 64'hD0);
        push(64'hD2);
        chk("t2_s1", kernel_start, 4'b0010);
        chk("t2_d1", kernel_data, 64'hD1);
        push(64'hD3);
        chk("t2_s2", kernel_start, 4'b0100);
        chk("t2_d2", kernel_data, 64'hD2);
        @(negedge clk);
        chk("t2_s3", kernel_start, 4'b1000);
        chk("t2_d3", kernel_data, 64'hD3);
        chk("t2_busy", busy_o, 4'hF);
        complete_ready = 4'hF;
        set_cd(0, 41'h100); set_cd(1, 41'h101); set_cd(2, 41'h102); set_cd(3, 41'h103);
        #1 chk("t2_acc0", complete_accept, 4'b0001);
        @(negedge clk);
        complete_ready = 4'b1110;
        chk("t2_kid0", return_kid_o, 0);
        chk("t2_rd0", return_data_o, 41'h100);
        #1 chk("t2_acc1", complete_accept, 4'b0010);
        @(negedge clk);
        complete_ready = 4'b1100;
        chk("t2_kid1", return_kid_o, 1);
        chk("t2_rd1", return_data_o, 41'h101);
        #1 chk("t2_acc2", complete_accept, 4'b0100);
        @(negedge clk);
        complete_ready = 4'b1000;
        chk("t2_kid2", return_kid_o, 2);
        #1 chk("t2_acc3", complete_accept, 4'b1000);
        @(negedge clk);
        complete_ready = '0;
        chk("t2_kid3", return_kid_o, 3);
        chk("t2_rd3", return_data_o, 41'h103);
        chk("t2_ccnt", complete_cnt_o, 4);
        chk("t2_busy_clr", busy_o, 0);
        push(64'hD4);
        @(negedge clk);
        chk("t2_wrap", kernel_start, 4'b0001);
        chk("t2_dcnt", dispatch_cnt_o, 5);

        // fixed priority and enable mask
        do_reset;
        mode_i = 1'b1;
        push(64'hE0);
        @(negedge clk);
        chk("t2p_s0", kernel_start, 4'b0001);
        complete_ready = 4'b0001;
        @(negedge clk);
        complete_ready = '0;
        kernel_en_i = 4'b1110;
        push(64'hE1);
        @(negedge clk);
        chk("t2p_masked", kernel_start, 4'b0010);
        kernel_en_i = 4'hF;
        push(64'hE2);
        @(negedge clk);
        chk("t2p_prio", kernel_start, 4'b0001);
        chk("t2p_kdata", kernel_data, 64'hE2);
        mode_i = 1'b0;

        // FIFO full, refill while popping, nothing lost
        do_reset;
        kernel_ready = '0;
        dsc_ready_i = 1'b1;
        dsc_data_i = 64'hF0;
        #1 chk("t3_pull_empty", dsc_pull_o, 1);
        @(negedge clk) dsc_data_i = 64'hF1;
        @(negedge clk) dsc_data_i = 64'hF2;
        @(negedge clk) dsc_data_i = 64'hF3;
        @(negedge clk) dsc_data_i = 64'hF4;
        #1 chk("t3_full", dsc_pull_o, 0);
        @(negedge clk);
        chk("t3_full_hold", dsc_pull_o, 0);
        kernel_ready = 4'b0010;
        #1 chk("t3_pull_on_pop", dsc_pull_o, 1);
        @(negedge clk);
        chk("t3_s_f0", kernel_start, 4'b0010);
        chk("t3_d_f0", kernel_data, 64'hF0);
        dsc_data_i = 64'hF5;
        complete_ready = 4'b0010;
        set_cd(1, 41'h0AA);
        #1 chk("t3_acc1", complete_accept, 4'b0010);
        chk("t3_full_busy", dsc_pull_o, 0);
        @(negedge clk);
        complete_ready = '0;
        #1 chk("t3_pull_refill", dsc_pull_o, 1);
        @(negedge clk);
        dsc_ready_i = 1'b0;
        chk("t3_d_f1", kernel_data, 64'hF1);
        kernel_ready = 4'hF;
        @(negedge clk);
        chk("t3_s_f2", kernel_start, 4'b0100);
        chk("t3_d_f2", kernel_data, 64'hF2);
        @(negedge clk);
        chk("t3_s_f3", kernel_start, 4'b1000);
        chk("t3_d_f3", kernel_data, 64'hF3);
        @(negedge clk);
        chk("t3_s_f4", kernel_start, 4'b0001);
        chk("t3_d_f4", kernel_data, 64'hF4);
        @(negedge clk);
        chk("t3_all_busy", kernel_start, 0);
        chk("t3_dcnt5", dispatch_cnt_o, 5);
        complete_ready = 4'b0100;
        #1 chk("t3_acc2", complete_accept, 4'b0100);
        @(negedge clk);
        complete_ready = '0;
        chk("t3_collision", kernel_start, 0);
        @(negedge clk);
        chk("t3_s_f5", kernel_start, 4'b0100);
        chk("t3_d_f5", kernel_data, 64'hF5);
        chk("t3_dcnt6", dispatch_cnt_o, 6);

        // return back-pressure
        do_reset;
        complete_ready_i = 1'b0;
        push(64'h10);
        push(64'h11);
        push(64'h12);
        @(negedge clk);
        chk("t4_busy", busy_o, 4'b0111);
        complete_ready = 4'b0101;
        set_cd(0, 41'h0F0_0000_0000);
        set_cd(2, 41'h022_2222_2222);
        #1 chk("t4_acc0", complete_accept, 4'b0001);
        @(negedge clk);
        complete_ready = 4'b0100;
        chk("t4_push", complete_push_o, 1);
        chk("t4_kid0", return_kid_o, 0);
        #1 chk("t4_no_acc", complete_accept, 0);
        @(negedge clk);
        chk("t4_push_held", complete_push_o, 1);
        chk("t4_kid0_held", return_kid_o, 0);
        chk("t4_data_held", return_data_o, 41'h0F0_0000_0000);
        chk("t4_busy2", busy_o, 4'b0110);
        complete_ready_i = 1'b1;
        #1 chk("t4_acc2", complete_accept, 4'b0100);
        @(negedge clk);
        complete_ready = '0;
        chk("t4_push2", complete_push_o, 1);
        chk("t4_kid2", return_kid_o, 2);
        chk("t4_data2", return_data_o, 41'h022_2222_2222);
        chk("t4_ccnt", complete_cnt_o, 2);
        @(negedge clk);
        chk("t4_push_drop", complete_push_o, 0);

        // spurious completion and flush
        complete_ready = 4'b1000;
        #1 chk("t5_no_acc", complete_accept, 0);
        @(negedge clk);
        complete_ready = '0;
        chk("t5_err", err_spurious_o, 1);
        @(negedge clk);
        chk("t5_err_sticky", err_spurious_o, 1);
        kernel_ready = '0;
        push(64'h20);
        push(64'h21);
        push(64'h22);
        chk("t5_not_idle", idle_o, 0);
        kernel_ready = 4'hF;
        flush_i = 1'b1;
        #1 chk("t5_flush_pull", dsc_pull_o, 0);
        @(negedge clk);
        flush_i = 1'b0;
        chk("t5_flush_nostart", kernel_start, 0);
        chk("t5_flush_busy", busy_o, 4'b0010);
        chk("t5_flush_dcnt", dispatch_cnt_o, 3);
        @(negedge clk);
        chk("t5_empty_nostart", kernel_start, 0);
        chk("t5_idle_busy", idle_o, 0);
        complete_ready = 4'b0010;
        set_cd(1, 41'h055);
        #1 chk("t5_acc1", complete_accept, 4'b0010);
        @(negedge clk);
        complete_ready = '0;
        chk("t5_idle_push", idle_o, 0);
        @(negedge clk);
        chk("t5_idle", idle_o, 1);
        chk("t5_ccnt", complete_cnt_o, 3);

        // asynchronous reset mid-operation
        complete_ready_i = 1'b0;
        push(64'h30);
        push(64'h31);
        push(64'h32);
        @(negedge clk);
        complete_ready = 4'b1000;
        @(negedge clk);
        complete_ready = '0;
        chk("t6_busy", busy_o, 4'b0011);
        chk("t6_push", complete_push_o, 1);
        #2 resetn = 1'b0;
        #1;
        chk("t6_start", kernel_start, 0);
        chk("t6_kdata", kernel_data, 0);
        chk("t6_busy0", busy_o, 0);
        chk("t6_push0", complete_push_o, 0);
        chk("t6_rdata", return_data_o, 0);
        chk("t6_kid", return_kid_o, 0);
        chk("t6_dcnt", dispatch_cnt_o, 0);
        chk("t6_ccnt", complete_cnt_o, 0);
        chk("t6_err", err_spurious_o, 0);
        chk("t6_idle", idle_o, 1);
        @(negedge clk);
        resetn = 1'b1;
        complete_ready_i = 1'b1;
        push(64'h40);
        @(negedge clk);
        chk("t6_first_k0", kernel_start, 4'b0001);
        chk("t6_first_data", kernel_data, 64'h40);
        chk("t6_dcnt1", dispatch_cnt_o, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
